// File: rtl/sha256_pkg.sv
// Shared sizing and FSM state type for the SHA-256 digest serialiser.
package sha256_pkg;

  localparam int unsigned HASH_W         = 256;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned WORDS_PER_HASH = 8;
  localparam int unsigned CNT_W          = 3;
  localparam int unsigned DROP_W         = 10;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/sha256_hash_serialiser.sv
// Serialises a 256-bit digest into eight 32-bit words, MSW first.
// Optional SHA256_HASH_SERIALISER_ERR_DROP_EN: consume and count erroneous digests.
module sha256_hash_serialiser
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              nrst,
  input  logic              en,
  input  logic              sync_rst,
  input  logic [HASH_W-1:0] hash_in,
  input  logic              hash_in_err,
  input  logic              hash_in_last,
  input  logic              hash_in_valid,
  output logic              hash_in_ready,
  output logic [WORD_W-1:0] data_out,
  output logic              data_out_err,
  output logic              data_out_hash_last,
  output logic              data_out_last,
  output logic              data_out_valid,
  input  logic              data_out_ready,
  output logic [DROP_W-1:0] status_drop_count
);

  state_t            state, state_n;
  logic [CNT_W-1:0]  word_cnt, word_cnt_n;
  logic [HASH_W-1:0] hash_reg, hash_reg_n;
  logic              err_reg, err_reg_n;
  logic              last_reg, last_reg_n;

  logic active;
  logic word7;
  logic cap;
  logic out_hs;
  logic drop_now;

  // Handshakes are suppressed while any reset is asserted or en is low.
  assign active = nrst & ~sync_rst & en;
  assign word7  = (word_cnt == CNT_W'(WORDS_PER_HASH - 1));

  assign data_out_valid = active & (state == SHIFT);
  assign hash_in_ready  = active & ((state == IDLE) |
                                    ((state == SHIFT) & word7 & data_out_ready));

  assign cap    = hash_in_valid & hash_in_ready;
  assign out_hs = data_out_valid & data_out_ready;

  assign data_out           = hash_reg[(HASH_W - 1) - (WORD_W * int'(word_cnt)) -: WORD_W];
  assign data_out_err       = err_reg;
  assign data_out_hash_last = (state == SHIFT) & word7;
  assign data_out_last      = (state == SHIFT) & word7 & last_reg;

`ifdef SHA256_HASH_SERIALISER_ERR_DROP_EN
  logic [DROP_W-1:0] drop_cnt, drop_cnt_n;

  assign drop_now          = cap & hash_in_err;
  assign status_drop_count = drop_cnt;

  always_comb begin
    drop_cnt_n = drop_cnt;
    if (drop_now && (drop_cnt != '1))
      drop_cnt_n = drop_cnt + DROP_W'(1);
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst)         drop_cnt <= '0;
    else if (sync_rst) drop_cnt <= '0;
    else if (en)       drop_cnt <= drop_cnt_n;
  end
`else
  assign drop_now          = 1'b0;
  assign status_drop_count = '0;
`endif

  // A capture on the word-7 handshake overrides the return to IDLE, giving gapless digests.
  always_comb begin
    state_n    = state;
    word_cnt_n = word_cnt;
    hash_reg_n = hash_reg;
    err_reg_n  = err_reg;
    last_reg_n = last_reg;
    if (out_hs) begin
      if (word7) begin
        state_n    = IDLE;
        word_cnt_n = '0;
      end else begin
        word_cnt_n = word_cnt + CNT_W'(1);
      end
    end
    if (cap && !drop_now) begin
      state_n    = SHIFT;
      word_cnt_n = '0;
      hash_reg_n = hash_in;
      err_reg_n  = hash_in_err;
      last_reg_n = hash_in_last;
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      word_cnt <= '0;
      hash_reg <= '0;
      err_reg  <= 1'b0;
      last_reg <= 1'b0;
    end else if (sync_rst) begin
      state    <= IDLE;
      word_cnt <= '0;
      hash_reg <= '0;
      err_reg  <= 1'b0;
      last_reg <= 1'b0;
    end else if (en) begin
      state    <= state_n;
      word_cnt <= word_cnt_n;
      hash_reg <= hash_reg_n;
      err_reg  <= err_reg_n;
      last_reg <= last_reg_n;
    end
  end

endmodule

// File: tb/tb_sha256_hash_serialiser.sv
// Scoreboard bench for sha256_hash_serialiser; honours SHA256_HASH_SERIALISER_ERR_DROP_EN.
module tb_sha256_hash_serialiser;

`ifdef SHA256_HASH_SERIALISER_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         nrst = 1'b0;
  logic         en = 1'b1;
  logic         sync_rst = 1'b0;
  logic [255:0] hash_in = '0;
  logic         hash_in_err = 1'b0;
  logic         hash_in_last = 1'b0;
  logic         hash_in_valid = 1'b0;
  logic         hash_in_ready;
  logic [31:0]  data_out;
  logic         data_out_err;
  logic         data_out_hash_last;
  logic         data_out_last;
  logic         data_out_valid;
  logic         data_out_ready = 1'b1;
  logic [9:0]   status_drop_count;

  sha256_hash_serialiser dut (
    .clk                (clk),
    .nrst               (nrst),
    .en                 (en),
    .sync_rst           (sync_rst),
    .hash_in            (hash_in),
    .hash_in_err        (hash_in_err),
    .hash_in_last       (hash_in_last),
    .hash_in_valid      (hash_in_valid),
    .hash_in_ready      (hash_in_ready),
    .data_out           (data_out),
    .data_out_err       (data_out_err),
    .data_out_hash_last (data_out_hash_last),
    .data_out_last      (data_out_last),
    .data_out_valid     (data_out_valid),
    .data_out_ready     (data_out_ready),
    .status_drop_count  (status_drop_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        err;
    logic        hlast;
    logic        last;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid word is checked against the queue head; popped on handshake.
  always @(negedge clk) begin
    if (nrst && data_out_valid) begin
      if (q.size() == 0) begin
        check("unexpected_word", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = q[0];
        check("word_data", data_out, e.d);
        check("word_err", {31'd0, data_out_err}, {31'd0, e.err});
        check("word_hash_last", {31'd0, data_out_hash_last}, {31'd0, e.hlast});
        check("word_last", {31'd0, data_out_last}, {31'd0, e.last});
        check("word_in_ready", {31'd0, hash_in_ready}, {31'd0, e.hlast & data_out_ready});
        if (data_out_ready) void'(q.pop_front());
      end
    end
  end

  // Call at posedge+1; returns at posedge+1 after acceptance.
  task automatic send(input logic [0:7][31:0] w, input logic err, input logic last);
    bit r;
    if (!(DROP && err)) begin
      for (int i = 0; i < 8; i++) begin
        exp_t e;
        e.d     = w[i];
        e.err   = err;
        e.hlast = (i == 7);
        e.last  = last && (i == 7);
        q.push_back(e);
      end
    end
    hash_in       = w;
    hash_in_err   = err;
    hash_in_last  = last;
    hash_in_valid = 1'b1;
    r = 1'b0;
    for (int k = 0; k < 200 && !r; k++) begin
      @(negedge clk);
      r = hash_in_ready;
      @(posedge clk);
    end
    check("accept", {31'd0, r}, 32'd1);
    #1 hash_in_valid = 1'b0;
  endtask

  task automatic expect_burst(input int n);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clk);
      seen = data_out_valid;
    end
    check("burst_start", {31'd0, seen}, 32'd1);
    for (int i = 0; i < n; i++) begin
      check("burst_valid", {31'd0, data_out_valid}, 32'd1);
      @(negedge clk);
    end
    check("burst_end", {31'd0, data_out_valid}, 32'd0);
  endtask

  task automatic wait_word(input logic [31:0] v);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 100 && !found; k++) begin
      @(negedge clk);
      found = data_out_valid && data_out_ready && (data_out == v);
    end
    check("trigger", {31'd0, found}, 32'd1);
  endtask

  task automatic drain();
    for (int k = 0; k < 300 && q.size() != 0; k++) @(negedge clk);
    check("drain", q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int nv;

    // Reset state
    @(negedge clk);
    check("rst_valid", {31'd0, data_out_valid}, 32'd0);
    check("rst_in_ready", {31'd0, hash_in_ready}, 32'd0);
    check("rst_data", data_out, 32'd0);
    check("rst_flags", {29'd0, data_out_err, data_out_last, data_out_hash_last}, 32'd0);
    check("rst_drop", {22'd0, status_drop_count}, 32'd0);
    #3 nrst = 1'b1;
    @(posedge clk);
    #1;

    // Single digest, words 1..8
    fork
      send({32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8}, 1'b0, 1'b1);
      expect_burst(8);
    join
    drain();

    // Back-to-back digests: 16 words, no gap
    fork
      begin
        send({32'hA0000000, 32'hA1111111, 32'hA2222222, 32'hA3333333,
              32'hA4444444, 32'hA5555555, 32'hA6666666, 32'hA7777777}, 1'b0, 1'b0);
        send({32'hB0000000, 32'hB1111111, 32'hB2222222, 32'hB3333333,
              32'hB4444444, 32'hB5555555, 32'hB6666666, 32'hB7777777}, 1'b0, 1'b1);
      end
      expect_burst(16);
    join
    drain();

    // Downstream stall on word 4 for three cycles
    fork
      send({32'hC0C0C0C0, 32'hC1C1C1C1, 32'hC2C2C2C2, 32'hC3C3C3C3,
            32'hC4C4C4C4, 32'hC5C5C5C5, 32'hC6C6C6C6, 32'hC7C7C7C7}, 1'b0, 1'b1);
      begin
        wait_word(32'hC3C3C3C3);
        @(posedge clk);
        #1 data_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 data_out_ready = 1'b1;
      end
    join
    drain();

    // Erroneous digest
    check("drop_before", {22'd0, status_drop_count}, 32'd0);
    send({32'hDEAD0000, 32'hDEAD0001, 32'hDEAD0002, 32'hDEAD0003,
          32'hDEAD0004, 32'hDEAD0005, 32'hDEAD0006, 32'hDEAD0007}, 1'b1, 1'b0);
`ifdef SHA256_HASH_SERIALISER_ERR_DROP_EN
    nv = 0;
    repeat (12) begin
      @(negedge clk);
      if (data_out_valid) nv++;
    end
    check("drop_no_words", nv, 32'd0);
    check("drop_after", {22'd0, status_drop_count}, 32'd1);
    @(posedge clk);
    #1;
`else
    drain();
    check("drop_after", {22'd0, status_drop_count}, 32'd0);
`endif

    // sync_rst after word 2
    fork
      send({32'hE0000001, 32'hE0000002, 32'hE0000003, 32'hE0000004,
            32'hE0000005, 32'hE0000006, 32'hE0000007, 32'hE0000008}, 1'b0, 1'b1);
      wait_word(32'hE0000003);
    join
    @(posedge clk);
    #1 sync_rst = 1'b1;
    @(negedge clk);
    check("srst_valid", {31'd0, data_out_valid}, 32'd0);
    check("srst_in_ready", {31'd0, hash_in_ready}, 32'd0);
    @(posedge clk);
    #1 sync_rst = 1'b0;
    q.delete();
    @(negedge clk);
    check("srst_idle_valid", {31'd0, data_out_valid}, 32'd0);
    check("srst_data", data_out, 32'd0);
    check("srst_drop", {22'd0, status_drop_count}, 32'd0);
    @(posedge clk);
    #1;
    fork
      send({32'hF0F00000, 32'hF0F00001, 32'hF0F00002, 32'hF0F00003,
            32'hF0F00004, 32'hF0F00005, 32'hF0F00006, 32'hF0F00007}, 1'b0, 1'b1);
      expect_burst(8);
    join
    drain();

    // en low for 5 cycles mid-digest
    fork
      send({32'h12345678, 32'h23456789, 32'h3456789A, 32'h456789AB,
            32'h56789ABC, 32'h6789ABCD, 32'h789ABCDE, 32'h89ABCDEF}, 1'b0, 1'b0);
      wait_word(32'h6789ABCD);
    join
    @(posedge clk);
    #1 en = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("en_low_valid", {31'd0, data_out_valid}, 32'd0);
      check("en_low_in_ready", {31'd0, hash_in_ready}, 32'd0);
    end
    @(posedge clk);
    #1 en = 1'b1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sha256_hash_serialiser.md
SHA256_HASH_SERIALISER -- requirements
Module: sha256_hash_serialiser

Interface
REQ-001 SHALL have port clk  input  1  clock; all state on rising edge.
REQ-002 SHALL have port nrst  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port en  input  1  enable; low freezes all state and blocks handshakes.
REQ-004 SHALL have port sync_rst  input  1  synchronous reset to reset values; priority over en.
REQ-005 SHALL have port hash_in  input  256  digest from upstream ID validator.
REQ-006 SHALL have port hash_in_err  input  1  ID-mismatch flag for this digest.
REQ-007 SHALL have port hash_in_last  input  1  digest closes a packet.
REQ-008 SHALL have ports hash_in_valid input 1 / hash_in_ready output 1: upstream handshake.
REQ-009 SHALL have port data_out  output  32  serialised digest word.
REQ-010 SHALL have port data_out_err  output  1  copy of captured hash_in_err, held on all 8 words.
REQ-011 SHALL have port data_out_hash_last  output  1  high on word 7 of every digest.
REQ-012 SHALL have port data_out_last  output  1  high on word 7 only if captured hash_in_last=1.
REQ-013 SHALL have ports data_out_valid output 1 / data_out_ready input 1: downstream handshake.
REQ-014 SHALL have port status_drop_count  output  10  count of dropped erroneous digests.

Function
REQ-015 SHALL implement states IDLE (holding register empty) and SHIFT (emitting words 0..7).
REQ-016 SHALL capture hash_in/err/last on hash_in_valid&hash_in_ready; IDLE->SHIFT, word_cnt=0.
REQ-017 SHALL emit words MSW first: word k = hash[255-32k -: 32]; word 0 = bits 255:224.
REQ-018 SHALL assert data_out_valid the cycle after capture (latency 1); hold data until data_out_ready.
REQ-019 SHALL advance word_cnt (3-bit) only on data_out_valid&data_out_ready; data stable while stalled.
REQ-020 SHALL drive hash_in_ready = en & (IDLE | (SHIFT & word_cnt==7 & data_out_ready)).
REQ-021 SHALL, on word-7 handshake with simultaneous capture, stay in SHIFT with word_cnt=0 (no bubble, 8 cycles/digest).
REQ-022 SHALL, on word-7 handshake without capture, return to IDLE and drop data_out_valid next cycle.
REQ-023 SHALL, while en=0, drive hash_in_ready=0 and data_out_valid=0 and hold state, word_cnt, register.
REQ-024 SHALL never deassert data_out_valid mid-digest except via en=0, sync_rst or nrst.

Reset
REQ-025 SHALL on nrst low or sync_rst high set state=IDLE, word_cnt=0, register=0.
REQ-026 SHALL reset outputs: data_out=0, data_out_err=0, data_out_last=0, data_out_hash_last=0, data_out_valid=0, hash_in_ready=0 during reset, status_drop_count=0.
REQ-027 SHALL discard a partially emitted digest on reset mid-SHIFT; no further words of it emitted.

Configuration
REQ-028 SHALL honour macro SHA256_HASH_SERIALISER_ERR_DROP_EN.
REQ-029 SHALL, when defined, consume digests with hash_in_err=1 without entering SHIFT, increment status_drop_count (saturating at 1023), keep hash_in_ready high in IDLE.
REQ-030 SHALL, when undefined, forward erroneous digests with data_out_err=1 and tie status_drop_count to 0.

Structure
REQ-031 SHALL take HASH_W=256, WORD_W=32, WORDS_PER_HASH=8 and the state enum from shared package sha256_pkg.
REQ-032 SHALL be a single module with no sub-modules.

Verification
REQ-033 SHALL cover: digest 0x0001..0008 per word, err=0, last=1, ready always 1 -> words 0x00000001..0x00000008 on 8 consecutive cycles, data_out_last on word 7 only.
REQ-034 SHALL cover: two digests presented back-to-back, ready=1 -> 16 consecutive valid words, no gap, hash_in_ready high exactly on word-7 cycles.
REQ-035 SHALL cover: data_out_ready low 3 cycles at word 4 -> word 4 held stable, no skip/repeat, hash_in_ready=0 throughout.
REQ-036 SHALL cover: err=1 digest, macro defined -> no output words, status_drop_count 0->1; undefined -> 8 words with data_out_err=1.
REQ-037 SHALL cover: sync_rst pulse after word 2 -> data_out_valid=0 next cycle, next digest starts at word 0.
REQ-038 SHALL cover: en=0 for 5 cycles mid-digest -> valid/ready low, resumes at same word when en=1.
